// File: rtl/mips_mem_responder.sv
// Single-port word RAM serving the MIPS core's fetch and data ports.
// A data access takes the RAM for one cycle and raises stall; the next cycle (DONE) fetches.
module mips_mem_responder #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pcF,
  output logic [31:0] instrF,
  output logic        instr_validF,
  input  logic        memenM,
  input  logic        memwriteM,
  input  logic [3:0]  beM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  output logic [31:0] readdataM,
  output logic        data_validM,
  output logic        err_misalignM,
  output logic        stall
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {IDLE, DONE} state_t;

  state_t state_q, state_d;

  logic [31:0] mem [0:DEPTH-1];

  logic [31:0]           instr_q;
  logic                  ivalid_q;
  logic [31:0]           rd_q;
  logic                  dvalid_q;
  logic                  err_q;
  logic                  fetch;
  logic                  access;
  logic                  misalign;
  logic                  write_en;
  logic [ADDR_WIDTH-1:0] pc_idx;
  logic [ADDR_WIDTH-1:0] data_idx;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [31:0]           ram_rdata;

  assign pc_idx    = pcF[ADDR_WIDTH+1:2];
  assign data_idx  = aluoutM[ADDR_WIDTH+1:2];
  assign ram_addr  = access ? data_idx : pc_idx;
  assign ram_rdata = mem[ram_addr];

  always_comb begin
    state_d  = state_q;
    stall    = 1'b0;
    fetch    = 1'b0;
    access   = 1'b0;
    write_en = 1'b0;
    misalign = memenM && (beM == 4'hF) && (aluoutM[1:0] != 2'b00);
    case (state_q)
      IDLE: begin
        if (memenM) begin
          stall    = 1'b1;
          access   = 1'b1;
          write_en = memwriteM && !misalign;
          state_d  = DONE;
        end else begin
          fetch = 1'b1;
        end
      end
      DONE: begin
        // Request still on the bus here was already served at the IDLE edge.
        fetch   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      instr_q  <= '0;
      ivalid_q <= 1'b0;
      rd_q     <= '0;
      dvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      dvalid_q <= access && !memwriteM;
      err_q    <= access && misalign;
      if (fetch) begin
        instr_q  <= ram_rdata;
        ivalid_q <= 1'b1;
      end else if (access) begin
        ivalid_q <= 1'b0;
      end
      if (access && misalign) begin
        rd_q <= '0;
      end else if (access && !memwriteM) begin
        rd_q <= ram_rdata;
      end
    end
  end

  // Contents are not reset; reset only blocks a store on the same edge.
  always_ff @(posedge clk) begin
    if (!rst && write_en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (beM[i]) mem[data_idx][8*i +: 8] <= writedataM[8*i +: 8];
      end
    end
  end

  assign instrF        = instr_q;
  assign instr_validF  = ivalid_q;
  assign readdataM     = rd_q;
  assign data_validM   = dvalid_q;
  assign err_misalignM = err_q;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Bench for mips_mem_responder: directed table, reset corner sequences, then random traffic
// checked against a word-array model of the RAM and the two-cycle access protocol.
module tb_mips_mem_responder;

  localparam int AW = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pcF;
  logic [31:0] instrF;
  logic        instr_validF;
  logic        memenM;
  logic        memwriteM;
  logic [3:0]  beM;
  logic [31:0] aluoutM;
  logic [31:0] writedataM;
  logic [31:0] readdataM;
  logic        data_validM;
  logic        err_misalignM;
  logic        stall;

  mips_mem_responder #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .pcF(pcF), .instrF(instrF), .instr_validF(instr_validF),
    .memenM(memenM), .memwriteM(memwriteM), .beM(beM), .aluoutM(aluoutM),
    .writedataM(writedataM), .readdataM(readdataM), .data_validM(data_validM),
    .err_misalignM(err_misalignM), .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          op;   // 0 fetch, 1 load, 2 store
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;  // expected instrF (fetch) or readdataM (load)
  } vec_t;

  vec_t        tbl [16];
  logic [31:0] ref_mem [0:(1<<AW)-1];
  logic [31:0] exp_instr;
  logic [31:0] exp_rd;
  int          nvec = 0;
  int          nerr = 0;

  function automatic int widx(input logic [31:0] a);
    return int'(a[AW+1:2]);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_fetch(input logic [31:0] pc);
    memenM = 1'b0; memwriteM = 1'b0; beM = 4'h0; pcF = pc;
    #1 chk("stall_fetch", stall, 0);
    tick;
    exp_instr = ref_mem[widx(pc)];
    chk("fetch_instr", instrF, exp_instr);
    chk("fetch_ivalid", instr_validF, 1);
    chk("fetch_dvalid", data_validM, 0);
    chk("fetch_err", err_misalignM, 0);
    chk("fetch_rd_hold", readdataM, exp_rd);
  endtask

  task automatic run_access(input logic we, input logic [3:0] be, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] pc,
                            output logic [31:0] got);
    logic mis;
    memenM = 1'b1; memwriteM = we; beM = be; aluoutM = addr; writedataM = wdata; pcF = pc;
    #1 chk("stall_idle", stall, 1);
    mis = (be == 4'hF) && (addr[1:0] != 2'b00);
    if (mis) exp_rd = '0;
    else if (!we) exp_rd = ref_mem[widx(addr)];
    else begin
      for (int l = 0; l < 4; l++)
        if (be[l]) ref_mem[widx(addr)][8*l +: 8] = wdata[8*l +: 8];
    end
    tick;
    chk("acc_rd", readdataM, exp_rd);
    chk("acc_dvalid", data_validM, {31'b0, !we});
    chk("acc_err", err_misalignM, {31'b0, mis});
    chk("acc_ivalid", instr_validF, 0);
    chk("acc_instr_hold", instrF, exp_instr);
    got = readdataM;
    #1 chk("stall_done", stall, 0);
    tick;
    exp_instr = ref_mem[widx(pc)];
    chk("done_instr", instrF, exp_instr);
    chk("done_ivalid", instr_validF, 1);
    chk("done_dvalid", data_validM, 0);
    chk("done_err", err_misalignM, 0);
    chk("done_rd_hold", readdataM, exp_rd);
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] a;
    logic [31:0] p;

    tbl[0]  = '{2, 4'hF, 32'h0000_0000, 32'h0000_0011, 32'h0};
    tbl[1]  = '{2, 4'hF, 32'h0000_0004, 32'h0000_0022, 32'h0};
    tbl[2]  = '{2, 4'hF, 32'h0000_0008, 32'h0000_0033, 32'h0};
    tbl[3]  = '{2, 4'hF, 32'h0000_000C, 32'h0000_0044, 32'h0};
    tbl[4]  = '{0, 4'h0, 32'h0000_0000, 32'h0, 32'h0000_0011};
    tbl[5]  = '{0, 4'h0, 32'h0000_0004, 32'h0, 32'h0000_0022};
    tbl[6]  = '{0, 4'h0, 32'h0000_0008, 32'h0, 32'h0000_0033};
    tbl[7]  = '{0, 4'h0, 32'h0000_000C, 32'h0, 32'h0000_0044};
    tbl[8]  = '{2, 4'hF, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0};
    tbl[9]  = '{1, 4'hF, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF};
    tbl[10] = '{2, 4'hF, 32'h0000_0010, 32'h0102_0304, 32'h0};
    tbl[11] = '{2, 4'h5, 32'h0000_0010, 32'hAABB_CCDD, 32'h0};
    tbl[12] = '{1, 4'hF, 32'h0000_0010, 32'h0, 32'h01BB_03DD};
    tbl[13] = '{1, 4'hF, 32'h0000_0042, 32'h0, 32'h0000_0000};
    tbl[14] = '{1, 4'hF, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF};
    tbl[15] = '{2, 4'hF, 32'h0000_1008, 32'hCAFE_F00D, 32'h0};

    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = 'x;

    // Reset held two cycles with a store pending on the bus
    rst = 1'b1; memenM = 1'b1; memwriteM = 1'b1; beM = 4'hF;
    aluoutM = 32'h80; writedataM = 32'hBAD0_BAD0; pcF = '0;
    tick; tick;
    rst = 1'b0;
    exp_instr = '0; exp_rd = '0;
    chk("rst_instr", instrF, 0);
    chk("rst_ivalid", instr_validF, 0);
    chk("rst_rd", readdataM, 0);
    chk("rst_dvalid", data_validM, 0);
    chk("rst_err", err_misalignM, 0);
    chk("rst_stall", stall, 1);
    memenM = 1'b0;

    for (int i = 0; i < 16; i++) begin
      case (tbl[i].op)
        0: begin
          run_fetch(tbl[i].addr);
          chk("tbl_instr", instrF, tbl[i].exp);
        end
        1: begin
          run_access(1'b0, tbl[i].be, tbl[i].addr, 32'h0, 32'h0, got);
          chk("tbl_rd", got, tbl[i].exp);
        end
        default: run_access(1'b1, tbl[i].be, tbl[i].addr, tbl[i].data, tbl[i].addr, got);
      endcase
    end
    run_access(1'b0, 4'hF, 32'h0000_0008, 32'h0, 32'h0, got);
    chk("wrap_rd", got, 32'hCAFE_F00D);

    // Reset coinciding with a store's IDLE edge: no write, FSM stays IDLE
    run_access(1'b1, 4'hF, 32'h80, 32'h5A5A_5A5A, 32'h0, got);
    memenM = 1'b1; memwriteM = 1'b1; beM = 4'hF; aluoutM = 32'h80; writedataM = 32'h0BAD_0BAD;
    rst = 1'b1;
    tick;
    chk("rstmid_stall", stall, 1);
    chk("rstmid_ivalid", instr_validF, 0);
    rst = 1'b0; memenM = 1'b0;
    exp_instr = '0; exp_rd = '0;
    run_access(1'b0, 4'hF, 32'h80, 32'h0, 32'h0, got);
    chk("rstmid_ram", got, 32'h5A5A_5A5A);

    // Reset during the DONE cycle of a load
    memenM = 1'b1; memwriteM = 1'b0; beM = 4'hF; aluoutM = 32'h80;
    tick;
    chk("rstdone_dvalid_pre", data_validM, 1);
    rst = 1'b1;
    tick;
    chk("rstdone_stall", stall, 1);
    chk("rstdone_rd", readdataM, 0);
    chk("rstdone_dvalid", data_validM, 0);
    rst = 1'b0; memenM = 1'b0;
    exp_instr = '0; exp_rd = '0;

    // Random traffic over a small initialised window, with aliased upper address bits
    for (int i = 0; i < 32; i++)
      run_access(1'b1, 4'hF, i * 4, $urandom, 32'h0, got);
    for (int n = 0; n < 400; n++) begin
      a = {$urandom_range(0, 1023), 12'h0} | (32'($urandom_range(0, 31)) << 2);
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom);
      p = {$urandom_range(0, 1023), 12'h0} | (32'($urandom_range(0, 31)) << 2);
      if ($urandom_range(0, 9) < 4) run_fetch(p);
      else run_access(1'($urandom), ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom),
                      a, $urandom, p, got);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mips_mem_responder.md
# mips_mem_responder

Memory-side responder for the pipelined MIPS core. It serves the core's instruction-fetch port (pcF → instrF) and data port (aluoutM/writedataM/memwriteM → readdataM) from one single-port word RAM. A data access always wins the RAM for one cycle, and the responder asserts `stall` so the core holds its fetch and memory stages. The block replaces the two ideal memories in the top level and is the RAM end of the core's memory interface.

## Interface
- `ADDR_WIDTH`, default 10: word-address width; RAM depth is 2^ADDR_WIDTH 32-bit words.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `pcF` in 32: fetch byte address. Only bits [ADDR_WIDTH+1:2] are used.
- `instrF` out 32: fetched word, registered.
- `instr_validF` out 1: `instrF` holds the word for the `pcF` presented in the previous cycle.
- `memenM` in 1: data access request. `memwriteM` and `beM` are ignored when `memenM` is 0.
- `memwriteM` in 1: 1 = store, 0 = load.
- `beM` in 4: byte enables for stores. `beM[i]` writes byte lane i (bits 8i+7:8i).
- `aluoutM` in 32: data byte address. Only bits [ADDR_WIDTH+1:2] are used.
- `writedataM` in 32: store data, already lane-aligned by the core.
- `readdataM` out 32: load result, registered.
- `data_validM` out 1: one-cycle pulse while `readdataM` holds a load result.
- `err_misalignM` out 1: one-cycle pulse for a rejected misaligned word access.
- `stall` out 1: combinational; while high, the core holds `pcF` and all M-stage inputs.

## Operation
- Two-state FSM: IDLE and DONE. Reset state is IDLE.
- `stall` = (state == IDLE) & `memenM`. It is 0 in DONE.
- Address index = address[ADDR_WIDTH+1:2]. Upper bits are ignored, so addresses wrap modulo the RAM size with no error.
- Misaligned: `memenM`=1 & `beM`=4'hF & `aluoutM[1:0]`≠0.
  - The access is suppressed: no write; `readdataM`←0.
  - `err_misalignM` pulses. `data_validM` pulses only if the access was a load.
  - The FSM still goes to DONE.
- IDLE edge with `memenM`=0 (fetch):
  - `instrF`←RAM[pcF index]; `instr_validF`←1.
  - `data_validM`←0; `err_misalignM`←0.
- IDLE edge with `memenM`=1 (data access):
  - Store: RAM lanes with `beM`=1 ← `writedataM` lanes. `data_validM`←0.
  - Load: `readdataM`←RAM[aluoutM index]; `data_validM`←1.
  - `instr_validF`←0; `instrF` keeps its value.
  - State→DONE.
- DONE edge:
  - Fetch as in IDLE.
  - `data_validM`←0; `err_misalignM`←0.
  - State→IDLE.
  - `memenM` is ignored in DONE. The core advances at this edge because `stall` is 0, so the request still on the bus is the one already served.
- Back-to-back memory instructions: each costs 2 cycles (IDLE stall cycle, then DONE).
- Store followed by a fetch of the same word: the DONE-cycle fetch returns the new data, because the write completed at the earlier edge.
- `readdataM` holds its last value until the next load or reset.
- RAM contents are not reset. Simulation preloads them externally via hierarchical `$readmemh`.

## Timing
- Reset values: state IDLE, `instrF`=0, `instr_validF`=0, `readdataM`=0, `data_validM`=0, `err_misalignM`=0. `stall` follows `memenM` immediately after reset.
- Reset priority: a store whose request edge coincides with `rst`=1 is not performed, and the FSM returns to IDLE. This covers reset asserted mid-access, including reset in DONE.
- Fetch latency: 1 cycle. `pcF` is sampled at edge N; `instrF` is valid in cycle N+1.
- Load latency: 1 cycle. Request at the IDLE edge N; `readdataM`/`data_validM` are valid in cycle N+1 (the DONE cycle).
- Fetch bubble: during the DONE cycle `instr_validF`=0; a valid fetch result follows one cycle later.
- There is no combinational path from any input to any output except `memenM`→`stall`.

## Test plan
- Reset: hold `rst` for 2 cycles with `memenM`=1 and `memwriteM`=1.
  - Required: all registered outputs 0; RAM word unchanged.
  - Required: `stall`=1 in the first cycle after release.
- Fetch stream: preload RAM[0..3]=0x11,0x22,0x33,0x44; step `pcF` through 0,4,8,0xC.
  - Required: `instrF` shows 0x11..0x44 one cycle behind, with `instr_validF`=1 throughout.
- Store then load to the same address: store 0xDEADBEEF to 0x40 with `beM`=F, then load 0x40.
  - Required: `stall` pattern 1,0,1,0.
  - Required: `readdataM`=0xDEADBEEF with `data_validM` high for exactly 1 cycle.
  - Required: `instr_validF`=0 in each DONE cycle.
- Byte store: RAM[0x10>>2]=0x01020304; store 0xAABBCCDD with `beM`=4'b0101.
  - Required: word reads back 0x01BB03DD.
- Misaligned word load at 0x42.
  - Required: `err_misalignM` pulses once; `readdataM`=0; RAM unchanged.
- Wrap and reset mid-access:
  - Store to address 4<<ADDR_WIDTH+0x8; required: RAM index 2 is written.
  - Assert `rst` on the IDLE edge of a store; required: no write, state IDLE.
